// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational ALU: 4x8 register file, 3-state issue FSM.
// Optional macro ALU_ISSUE_CTRL_IMM_EN enables the imm5 operand on alu_b when imm_sel=1.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  output logic [3:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_flag,
  output logic        res_valid,
  output logic [7:0]  res_data,
  output logic [3:0]  res_flag,
  output logic        err,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  localparam int unsigned DW = 8;
  localparam int unsigned OW = 4;
  localparam int unsigned NREG = 4;
  localparam logic [OW-1:0] OP_LAST_ALU = 4'd6;
  localparam logic [OW-1:0] OP_LOADI    = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [DW-1:0] regs [NREG];
  logic [1:0]    rd_q;
  logic [DW-1:0] imm_q;

  // Next-value signals produced by the combinational FSM process
  logic          accept;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [OW-1:0] alu_opcode_n;
  logic [DW-1:0] alu_a_n;
  logic [DW-1:0] alu_b_n;
  logic [1:0]    rd_n;
  logic [DW-1:0] imm_n;
  logic          res_valid_n;
  logic [DW-1:0] res_data_n;
  logic [OW-1:0] res_flag_n;
  logic          err_n;

  // Instruction field decode
  logic [OW-1:0] f_op;
  logic [1:0]    f_rd;
  logic [1:0]    f_ra;
  logic          f_isel;
  logic [1:0]    f_rb;
  logic [4:0]    f_imm5;

  assign f_op   = instr[15:12];
  assign f_rd   = instr[11:10];
  assign f_ra   = instr[9:8];
  assign f_isel = instr[7];
  assign f_rb   = instr[6:5];
  assign f_imm5 = instr[4:0];

  assign dbg_data = regs[dbg_sel];

  // Next state, operand capture and result formation
  always_comb begin
    state_n      = state;
    accept       = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;
    alu_opcode_n = alu_opcode;
    alu_a_n      = alu_a;
    alu_b_n      = alu_b;
    rd_n         = rd_q;
    imm_n        = imm_q;
    res_valid_n  = 1'b0;
    res_data_n   = res_data;
    res_flag_n   = res_flag;
    err_n        = 1'b0;

    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept       = 1'b1;
          state_n      = ISSUE;
          alu_opcode_n = f_op;
          alu_a_n      = regs[f_ra];
`ifdef ALU_ISSUE_CTRL_IMM_EN
          alu_b_n      = f_isel ? DW'({3'b000, f_imm5}) : regs[f_rb];
`else
          alu_b_n      = regs[f_rb];
`endif
          rd_n         = f_rd;
          imm_n        = instr[7:0];
        end
      end
      ISSUE: begin
        state_n     = DONE;
        res_valid_n = 1'b1;
        if (alu_opcode <= OP_LAST_ALU) begin
          wr_en      = 1'b1;
          wr_data    = alu_out;
          res_data_n = alu_out;
          res_flag_n = alu_flag;
        end else if (alu_opcode == OP_LOADI) begin
          wr_en      = 1'b1;
          wr_data    = imm_q;
          res_data_n = imm_q;
          res_flag_n = '0;
        end else begin
          res_data_n = '0;
          res_flag_n = '0;
          err_n      = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

`ifndef ALU_ISSUE_CTRL_IMM_EN
  // imm_sel/imm5 only steer alu_b when the immediate option is built in
  logic unused_c;
  assign unused_c = ^{f_isel, f_imm5, accept};
`endif

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_flag   <= '0;
      err        <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else begin
      state      <= state_n;
      in_ready   <= (state_n == IDLE);
      alu_opcode <= alu_opcode_n;
      alu_a      <= alu_a_n;
      alu_b      <= alu_b_n;
      rd_q       <= rd_n;
      imm_q      <= imm_n;
      res_valid  <= res_valid_n;
      res_data   <= res_data_n;
      res_flag   <= res_flag_n;
      err        <= err_n;
      if (wr_en) regs[rd_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flag;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [3:0]  res_flag;
  logic        err;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_flag(alu_flag), .res_valid(res_valid),
    .res_data(res_data), .res_flag(res_flag), .err(err),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: carry (add) > zero > negative
  logic [8:0] sum9;
  always_comb begin
    sum9    = {1'b0, alu_a} + {1'b0, alu_b};
    alu_out = 8'h00;
    case (alu_opcode)
      4'h0: alu_out = sum9[7:0];
      4'h1: alu_out = alu_a - alu_b;
      4'h2: alu_out = alu_a & alu_b;
      4'h3: alu_out = alu_a | alu_b;
      4'h4: alu_out = alu_a ^ alu_b;
      4'h5: alu_out = alu_a << alu_b[2:0];
      4'h6: alu_out = alu_a >> alu_b[2:0];
      default: alu_out = 8'h00;
    endcase
    if (alu_opcode == 4'h0 && sum9[8]) alu_flag = 4'b1000;
    else if (alu_out == 8'h00)         alu_flag = 4'b0010;
    else if (alu_out[7])               alu_flag = 4'b0100;
    else                               alu_flag = 4'b0000;
  end

  function automatic logic [15:0] op_i(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic isel,
                                       input logic [1:0] rb, input logic [4:0] imm5);
    return {op, rd, ra, isel, rb, imm5};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] d);
    return {4'hF, rd, 2'b00, d};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input logic [1:0] r, input logic [7:0] exp);
    dbg_sel = r;
    #1;
    chk($sformatf("reg R%0d", r), dbg_data, exp);
  endtask

  // Issue one instruction at a negedge and check the whole handshake/result window
  task automatic exec(input string tag, input logic [15:0] ins, input logic [7:0] exp_data,
                      input logic [3:0] exp_flag, input logic exp_err);
    int waited = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, " in_ready"}, 8'(in_ready), 8'd1);
    in_valid = 1'b1;
    instr    = ins;
    @(negedge clk);
    in_valid = 1'b0;
    instr    = 16'hxxxx;
    chk({tag, " issue res_valid"}, 8'(res_valid), 8'd0);
    chk({tag, " issue in_ready"}, 8'(in_ready), 8'd0);
    @(negedge clk);
    chk({tag, " done res_valid"}, 8'(res_valid), 8'd1);
    chk({tag, " res_data"}, res_data, exp_data);
    chk({tag, " res_flag"}, 8'(res_flag), 8'(exp_flag));
    chk({tag, " err"}, 8'(err), 8'(exp_err));
    @(negedge clk);
    chk({tag, " idle res_valid"}, 8'(res_valid), 8'd0);
    chk({tag, " idle err"}, 8'(err), 8'd0);
    chk({tag, " hold res_data"}, res_data, exp_data);
  endtask

  logic [15:0] stream [3];
  logic [7:0]  stream_exp [3];
  int idx;
  int nres;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    instr    = 16'h0000;
    dbg_sel  = 2'd0;

    // Reset state
    #12;
    chk("rst res_valid", 8'(res_valid), 8'd0);
    chk("rst res_data", res_data, 8'h00);
    chk("rst res_flag", 8'(res_flag), 8'h0);
    chk("rst err", 8'(err), 8'd0);
    chk("rst alu_opcode", 8'(alu_opcode), 8'h0);
    chk("rst alu_a", alu_a, 8'h00);
    chk("rst alu_b", alu_b, 8'h00);
    for (int r = 0; r < 4; r++) chk_reg(2'(r), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst in_ready", 8'(in_ready), 8'd1);

    // ADD with carry
    exec("ldi R1", ldi(2'd1, 8'hF0), 8'hF0, 4'b0000, 1'b0);
    exec("ldi R2", ldi(2'd2, 8'h20), 8'h20, 4'b0000, 1'b0);
    exec("add R3", op_i(4'h0, 2'd3, 2'd1, 1'b0, 2'd2, 5'd0), 8'h10, 4'b1000, 1'b0);
    chk_reg(2'd3, 8'h10);

    // SUB zero and negative
    exec("ldi R0", ldi(2'd0, 8'h05), 8'h05, 4'b0000, 1'b0);
    exec("ldi R1b", ldi(2'd1, 8'h05), 8'h05, 4'b0000, 1'b0);
    exec("sub zero", op_i(4'h1, 2'd2, 2'd0, 1'b0, 2'd1, 5'd0), 8'h00, 4'b0010, 1'b0);
    exec("sub neg", op_i(4'h1, 2'd2, 2'd0, 1'b0, 2'd3, 5'd0), 8'hF5, 4'b0100, 1'b0);
    chk_reg(2'd2, 8'hF5);

    // Illegal opcode leaves registers untouched
    exec("illegal", op_i(4'hA, 2'd0, 2'd1, 1'b0, 2'd2, 5'd0), 8'h00, 4'b0000, 1'b1);
    chk_reg(2'd0, 8'h05);
    chk_reg(2'd1, 8'h05);
    chk_reg(2'd2, 8'hF5);
    chk_reg(2'd3, 8'h10);

    // Immediate operand option (rb=R0 holds 05)
    exec("ldi R1c", ldi(2'd1, 8'h03), 8'h03, 4'b0000, 1'b0);
`ifdef ALU_ISSUE_CTRL_IMM_EN
    exec("xor imm", op_i(4'h4, 2'd2, 2'd1, 1'b1, 2'd0, 5'd3), 8'h00, 4'b0010, 1'b0);
`else
    exec("xor imm", op_i(4'h4, 2'd2, 2'd1, 1'b1, 2'd0, 5'd3), 8'h06, 4'b0000, 1'b0);
`endif

    // rd aliases both sources
    exec("add R0+R0", op_i(4'h0, 2'd0, 2'd0, 1'b0, 2'd0, 5'd0), 8'h0A, 4'b0000, 1'b0);
    chk_reg(2'd0, 8'h0A);
    exec("shl", op_i(4'h5, 2'd3, 2'd1, 1'b0, 2'd0, 5'd0), 8'h0C, 4'b0000, 1'b0);

    // Back-to-back stream with in_valid held high
    stream[0] = ldi(2'd0, 8'h11); stream_exp[0] = 8'h11;
    stream[1] = ldi(2'd1, 8'h22); stream_exp[1] = 8'h22;
    stream[2] = op_i(4'h0, 2'd2, 2'd0, 1'b0, 2'd1, 5'd0); stream_exp[2] = 8'h33;
    idx  = 0;
    nres = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stream in_ready c%0d", i), 8'(in_ready), 8'((i % 3) == 0));
      chk($sformatf("stream res_valid c%0d", i), 8'(res_valid), 8'((i % 3) == 2));
      if (res_valid) begin
        if (nres < 3) chk($sformatf("stream res_data %0d", nres), res_data, stream_exp[nres]);
        nres++;
      end
      if (idx < 3) begin
        in_valid = 1'b1;
        instr    = stream[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (in_ready && in_valid) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stream result count", 8'(nres), 8'd3);
    chk_reg(2'd2, 8'h33);

    // Reset during ISSUE aborts the instruction
    in_valid = 1'b1;
    instr    = ldi(2'd3, 8'h77);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("abort res_valid", 8'(res_valid), 8'd0);
    @(negedge clk);
    chk("abort res_valid held", 8'(res_valid), 8'd0);
    for (int r = 0; r < 4; r++) chk_reg(2'(r), 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post-abort res_valid c%0d", i), 8'(res_valid), 8'd0);
      chk($sformatf("post-abort in_ready c%0d", i), 8'(in_ready), 8'd1);
    end
    chk_reg(2'd3, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and reset rst_n; reset is asynchronous and active-low.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  controller can accept
- instr  in  16  [15:12] op, [11:10] rd, [9:8] ra, [7] imm_sel, [6:5] rb, [4:0] imm5; [7:0] is LOADI data
- alu_opcode  out  4  opcode to the external combinational ALU
- alu_a  out  8  ALU operand a
- alu_b  out  8  ALU operand b
- alu_out  in  8  ALU result
- alu_flag  in  4  ALU flag (1000 carry, 0100 negative, 0010 zero, 0000 none)
- res_valid  out  1  one-cycle completion pulse
- res_data  out  8  value written to rd (00 on error)
- res_flag  out  4  flag of the completed instruction
- err  out  1  illegal-opcode pulse, coincident with res_valid
- dbg_sel  in  2  register-file read select
- dbg_data  out  8  register[dbg_sel], combinational

Function
REQ-003 Register file: 4 x 8-bit registers R0..R3.
REQ-004 FSM states SHALL be IDLE, ISSUE, DONE; IDLE->ISSUE on in_valid&&in_ready, ISSUE->DONE unconditionally, DONE->IDLE unconditionally.
REQ-005 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE is ignored, and instr is not sampled.
REQ-006 On acceptance (edge k) alu_opcode<=op, alu_a<=R[ra], alu_b<=R[rb] (or immediate per REQ-014); all three are registered and hold until the next acceptance.
REQ-007 ALU ops 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 shl, 0110 shr: at the end of ISSUE (edge k+1) alu_out SHALL be written to R[rd] and alu_flag captured unmodified into res_flag.
REQ-008 Op 1111 (LOADI): R[rd]<=instr[7:0] at edge k+1, res_flag=0000, ALU inputs ignored.
REQ-009 Ops 0111..1110: no register write, res_data=00, res_flag=0000, err=1 in DONE.
REQ-010 res_valid (and err where applicable) SHALL be high exactly during DONE (cycle after edge k+1); accept-to-result latency is 2 cycles, throughput 1 instruction per 3 cycles.
REQ-011 res_data/res_flag SHALL hold their last values outside DONE.
REQ-012 Operand reads use register values before the write; rd equal to ra or rb is legal (e.g. R0<=R0+R0).
REQ-013 dbg_data reflects the post-write value from DONE onward.

Reset
REQ-015 rst_n low SHALL immediately force: state IDLE, R0..R3=00, alu_opcode=0000, alu_a=alu_b=00, res_valid=0, res_data=00, res_flag=0000, err=0; in_ready=1 after release.
REQ-016 Reset asserted mid-instruction SHALL abort it with no register write and no res_valid pulse.

Configuration
REQ-014 Macro ALU_ISSUE_CTRL_IMM_EN: when defined and imm_sel=1, alu_b SHALL be {3'b000, imm5}; when undefined, imm_sel is ignored and alu_b is always R[rb].

Verification
REQ-017 Reset, then LOADI R1=0xF0, LOADI R2=0x20, ADD R3=R1+R2 -> res_data=0x10, res_flag=1000, R3=0x10, res_valid 2 cycles after accept.
REQ-018 LOADI R0=0x05, R1=0x05; SUB R2=R0-R1 -> res_data=0x00, res_flag=0010; SUB R2=R0-R3 (R3=0x10) -> res_data=0xF5, res_flag=0100.
REQ-019 in_valid held high continuously with 3 instructions -> in_ready pulses once every 3 cycles, exactly 3 res_valid pulses, no instruction lost or duplicated.
REQ-020 op=1010 -> err=1 with res_valid, res_data=00, res_flag=0000, all registers unchanged.
REQ-021 With ALU_ISSUE_CTRL_IMM_EN, R1=0x03, XOR imm_sel=1, imm5=0x03 -> res_data=0x00, res_flag=0010; without the macro, the same instruction uses R[rb].
REQ-022 rst_n asserted during ISSUE -> no res_valid, all registers 00, in_ready=1 after release.
